cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_if.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Run-controller port bundle: switch/receiver inputs and instruction-memory write outputs.
// Handshake: i_rx_dv is a one-cycle valid with no ready; a word that cannot be stored is discarded and flagged by a one-cycle o_drop.
interface cpu_run_ctrl_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               i_run_sw;
   logic               i_step_sw;
   logic               i_rx_dv;
   logic [INSTR_W-1:0] i_rx_instr;
   logic               i_loopf;
   logic               o_we;
   logic [ADDR_W-1:0]  o_waddr;
   logic [INSTR_W-1:0] o_wdata;
   logic               o_cpu_en;
   logic [1:0]         o_state;
   logic [ADDR_W:0]    o_prog_len;
   logic               o_full;
   logic               o_drop;

   modport master (
      output i_run_sw, i_step_sw, i_rx_dv, i_rx_instr, i_loopf,
      input  o_we, o_waddr, o_wdata, o_cpu_en, o_state, o_prog_len, o_full, o_drop
   );

   modport slave (
      input  i_run_sw, i_step_sw, i_rx_dv, i_rx_instr, i_loopf,
      output o_we, o_waddr, o_wdata, o_cpu_en, o_state, o_prog_len, o_full, o_drop
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: loads a program from the receiver, then gates the CPU clock enable.
// Define CPU_RUN_CTRL_STEP_EN to enable the PAUSE state and single-step support.
module cpu_run_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic           i_Clk,
   input  logic           w_rst,
   cpu_run_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   state_t              state, state_nx;
   logic                run_q;
   logic                run_ev;
   logic [ADDR_W:0]     prog_len;
   logic                full;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [INSTR_W-1:0]  wdata;
   logic                cpu_en;
   logic                drop;

   assign run_ev = run_q & ~bus.i_run_sw;
   assign full   = (prog_len == CAP);

`ifdef CPU_RUN_CTRL_STEP_EN
   logic step_q;
   logic step_ev;
   logic step_pulse;
   assign step_ev = step_q & ~bus.i_step_sw;
`else
   logic unused_step;
   assign unused_step = bus.i_step_sw;
`endif

   // Run events outrank i_loopf, which outranks step events.
   always_comb begin
      state_nx = state;
`ifdef CPU_RUN_CTRL_STEP_EN
      step_pulse = 1'b0;
`endif
      case (state)
         S_LOAD: begin
            if (run_ev) begin
               if (prog_len != '0) state_nx = S_RUN;
            end
`ifdef CPU_RUN_CTRL_STEP_EN
            else if (step_ev) state_nx = S_PAUSE;
`endif
         end
         S_RUN: begin
            if (run_ev)            state_nx = S_LOAD;
            else if (bus.i_loopf)  state_nx = S_DONE;
`ifdef CPU_RUN_CTRL_STEP_EN
            else if (step_ev)      state_nx = S_PAUSE;
`endif
         end
         S_PAUSE: begin
`ifdef CPU_RUN_CTRL_STEP_EN
            if (run_ev)            state_nx = S_RUN;
            else if (bus.i_loopf)  state_nx = S_DONE;
            else if (step_ev)      step_pulse = 1'b1;
`else
            state_nx = S_LOAD;
`endif
         end
         default: begin
            if (run_ev) state_nx = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge w_rst) begin
      if (w_rst) begin
         state    <= S_LOAD;
         run_q    <= 1'b0;
`ifdef CPU_RUN_CTRL_STEP_EN
         step_q   <= 1'b0;
`endif
         prog_len <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         cpu_en   <= 1'b0;
         drop     <= 1'b0;
      end else begin
         run_q  <= bus.i_run_sw;
`ifdef CPU_RUN_CTRL_STEP_EN
         step_q <= bus.i_step_sw;
         cpu_en <= (state_nx == S_RUN) | step_pulse;
`else
         cpu_en <= (state_nx == S_RUN);
`endif
         state  <= state_nx;
         we     <= 1'b0;
         drop   <= 1'b0;
         if (bus.i_rx_dv) begin
            if (state == S_LOAD && !full) begin
               we       <= 1'b1;
               waddr    <= prog_len[ADDR_W-1:0];
               wdata    <= bus.i_rx_instr;
               prog_len <= prog_len + 1'b1;
            end else begin
               drop <= 1'b1;
            end
         end
         // Re-entering LOAD starts a fresh program.
         if (state_nx == S_LOAD && state != S_LOAD) prog_len <= '0;
      end
   end

   assign bus.o_we       = we;
   assign bus.o_waddr    = waddr;
   assign bus.o_wdata    = wdata;
   assign bus.o_cpu_en   = cpu_en;
   assign bus.o_state    = state;
   assign bus.o_prog_len = prog_len;
   assign bus.o_full     = full;
   assign bus.o_drop     = drop;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random stimulus against a queue-based program model.
module tb_cpu_run_ctrl;

  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 16;
  localparam int CAP     = 1 << ADDR_W;

  typedef struct packed {
    logic [1:0]      st;
    logic            cpu_en;
    logic [ADDR_W:0] len;
    logic            full;
    logic            we;
    logic            drop;
  } stat_t;

  // clock / reset
  logic i_Clk = 1'b0;
  logic w_rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  cpu_run_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();
  cpu_run_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .i_Clk (i_Clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  stat_t stat_q[$];
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  // reference model: the program is a queue of loaded words
  int m_st;
  logic m_run_prev;
  logic m_step_prev;
  logic [INSTR_W-1:0] prog[$];

  task automatic model_reset();
    m_st = 0;
    m_run_prev = 1'b0;
    m_step_prev = 1'b0;
    prog.delete();
    exp_q.delete();
    stat_q.delete();
  endtask

  task automatic model_step(input logic run, input logic step, input logic dv,
                            input logic [INSTR_W-1:0] instr, input logic loopf);
    logic run_ev, step_ev, pulse, we, drop;
    int nxt;
    stat_t s;
    run_ev = m_run_prev && !run;
    m_run_prev = run;
`ifdef CPU_RUN_CTRL_STEP_EN
    step_ev = m_step_prev && !step;
    m_step_prev = step;
`else
    step_ev = 1'b0;
    m_step_prev = step;
`endif
    pulse = 1'b0;
    nxt = m_st;
    case (m_st)
      0: if (run_ev) nxt = (prog.size() > 0) ? 1 : 0; else if (step_ev) nxt = 2;
      1: if (run_ev) nxt = 0; else if (loopf) nxt = 3; else if (step_ev) nxt = 2;
      2: if (run_ev) nxt = 1; else if (loopf) nxt = 3; else if (step_ev) pulse = 1'b1;
      default: if (run_ev) nxt = 0;
    endcase
    we = 1'b0;
    drop = 1'b0;
    if (dv) begin
      if (m_st == 0 && prog.size() < CAP) begin
        we = 1'b1;
        exp_q.push_back({ADDR_W'(prog.size()), instr});
        prog.push_back(instr);
      end else begin
        drop = 1'b1;
      end
    end
    if (nxt == 0 && m_st != 0) prog.delete();
    m_st = nxt;
    s.st = 2'(m_st);
    s.cpu_en = (nxt == 1) || pulse;
    s.len = (ADDR_W+1)'(prog.size());
    s.full = (prog.size() == CAP);
    s.we = we;
    s.drop = drop;
    stat_q.push_back(s);
  endtask

  // driver
  task automatic drive(input logic run, input logic step, input logic dv,
                       input logic [INSTR_W-1:0] instr, input logic loopf);
    @(negedge i_Clk);
    bus.i_run_sw = run;
    bus.i_step_sw = step;
    bus.i_rx_dv = dv;
    bus.i_rx_instr = instr;
    bus.i_loopf = loopf;
    model_step(run, step, dv, instr, loopf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic run_event();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.o_state), 0);
    chk({tag, "_prog_len"}, 32'(bus.o_prog_len), 0);
    chk({tag, "_we"}, 32'(bus.o_we), 0);
    chk({tag, "_waddr"}, 32'(bus.o_waddr), 0);
    chk({tag, "_wdata"}, 32'(bus.o_wdata), 0);
    chk({tag, "_cpu_en"}, 32'(bus.o_cpu_en), 0);
    chk({tag, "_drop"}, 32'(bus.o_drop), 0);
    chk({tag, "_full"}, 32'(bus.o_full), 0);
  endtask

  // monitor / scoreboard
  initial begin
    stat_t e, a;
    logic [ADDR_W+INSTR_W-1:0] w;
    forever begin
      @(posedge i_Clk);
      #1;
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        a.st = bus.o_state;
        a.cpu_en = bus.o_cpu_en;
        a.len = bus.o_prog_len;
        a.full = bus.o_full;
        a.we = bus.o_we;
        a.drop = bus.o_drop;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL status t=%0t actual st=%0d en=%b len=%0d full=%b we=%b drop=%b expected st=%0d en=%b len=%0d full=%b we=%b drop=%b",
                   $time, a.st, a.cpu_en, a.len, a.full, a.we, a.drop,
                   e.st, e.cpu_en, e.len, e.full, e.we, e.drop);
        end
      end
      if (bus.o_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write t=%0t actual addr=%0h data=%0h expected no write",
                   $time, bus.o_waddr, bus.o_wdata);
        end else begin
          w = exp_q.pop_front();
          if ({bus.o_waddr, bus.o_wdata} !== w) begin
            errors++;
            $display("FAIL write t=%0t actual addr=%0h data=%0h expected addr=%0h data=%0h",
                     $time, bus.o_waddr, bus.o_wdata, w[ADDR_W+INSTR_W-1:INSTR_W], w[INSTR_W-1:0]);
          end
        end
      end
    end
  end

  // main sequence
  initial begin
    logic run_r, step_r;
    bus.i_run_sw = 1'b0;
    bus.i_step_sw = 1'b0;
    bus.i_rx_dv = 1'b0;
    bus.i_rx_instr = '0;
    bus.i_loopf = 1'b0;
    model_reset();
    repeat (3) @(negedge i_Clk);
    check_reset("por");
    w_rst = 1'b0;

    // three words, then fill to capacity and overflow by one
    drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h6666, 1'b0);
    idle(2);

    // run, drop during run, finish, back to load
    run_event();
    drive(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    run_event();
    idle(1);

    // run with empty program stays in load
    run_event();
    idle(2);

    // one word, run, then run event together with loopf returns to load
    drive(1'b0, 1'b0, 1'b1, 16'h0BAD, 1'b0);
    run_event();
    idle(2);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);

`ifdef CPU_RUN_CTRL_STEP_EN
    drive(1'b0, 1'b0, 1'b1, 16'hC0DE, 1'b0);
    run_event();
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(2);
    end
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    run_event();
`endif

    // reset mid-run with a received word in the same cycle
    drive(1'b0, 1'b0, 1'b1, 16'hFACE, 1'b0);
    run_event();
    idle(2);
    @(negedge i_Clk);
    bus.i_rx_dv = 1'b1;
    bus.i_rx_instr = 16'h9999;
    w_rst = 1'b1;
    model_reset();
    #1;
    check_reset("rst_run");
    @(negedge i_Clk);
    bus.i_rx_dv = 1'b0;
    check_reset("rst_hold");
    @(negedge i_Clk);
    w_rst = 1'b0;
    idle(4);

    // random stimulus
    run_r = 1'b0;
    step_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) run_r = ~run_r;
      if ($urandom_range(0, 9) == 0) step_r = ~step_r;
      drive(run_r, step_r, ($urandom_range(0, 2) == 0), 16'($urandom),
            ($urandom_range(0, 19) == 0));
    end
    @(posedge i_Clk);
    #2;
    chk("status_q_drained", 32'(stat_q.size()), 0);
    chk("write_q_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
